instruction_fetch_unit: RTL and testbench

//  Instruction sequencer for the single-cycle accumulator CPU; the requesting end of the instruction-memory port.

---
 rtl/instruction_fetch_unit.sv | 56 +++++
 tb/tb_instruction_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, fetches into the IR, issues via valid/ready, and resolves jmp/jez/hlt
module instruction_fetch_unit #(
  parameter int PC_W = 6,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [15:0]     imem_addr,
  input  logic [15:0]     imem_data,
  output logic [15:0]     ir,
  output logic [PC_W-1:0] ir_pc,
  output logic            ir_valid,
  input  logic            ex_ready,
  input  logic            acc_zero,
  output logic            halted
);
  typedef enum logic [1:0] {FETCH, ISSUE, HALT} state_t;
  state_t state;
  logic [PC_W-1:0] pc, pc_inc, target, pc_next;
  logic [2:0] op;
  logic accept, is_hlt;
  assign imem_addr = 16'(pc);
  assign op = ir[15:13];
  assign pc_inc = pc + 1'b1;
  assign target = ir[PC_W-1:0];
  assign accept = ir_valid & ex_ready;
  assign is_hlt = op == 3'b111;
  // Operand bits above PC_W-1 are dropped by the target slice; pc_inc wraps naturally.
  assign pc_next = (op == 3'b100 || (op == 3'b101 && acc_zero)) ? target : is_hlt ? pc : pc_inc;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      ir <= 16'h0000;
      ir_pc <= '0;
      ir_valid <= 1'b0;
      halted <= 1'b0;
      state <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          ir <= imem_data;
          ir_pc <= pc;
          ir_valid <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (accept) begin
          ir_valid <= 1'b0;
          halted <= is_hlt;
          pc <= pc_next;
          state <= is_hlt ? HALT : FETCH;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scenario tasks against hand-computed fetch/branch/halt behaviour
module tb_instruction_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, ex_ready = 1'b0, acc_zero = 1'b0;
  logic [15:0] imem_addr, imem_data, ir;
  logic [5:0] ir_pc;
  logic ir_valid, halted;
  logic [15:0] mem [64];
  int n_checks = 0, n_fail = 0;

  instruction_fetch_unit #(.PC_W(6), .RESET_PC(6'd0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data), .ir(ir),
    .ir_pc(ir_pc), .ir_valid(ir_valid), .ex_ready(ex_ready), .acc_zero(acc_zero), .halted(halted)
  );

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr[5:0]];

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    ex_ready = 1'b0;
    acc_zero = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits (bounded) for a valid instruction, accepts it, returns one cycle after the accepting edge.
  task automatic accept_one(input logic az);
    int n = 0;
    while (!ir_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!ir_valid) begin
      n_fail++;
      $display("FAIL accept_wait: ir_valid=%0b required 1", ir_valid);
    end
    ex_ready = 1'b1;
    acc_zero = az;
    @(negedge clk);
    ex_ready = 1'b0;
    acc_zero = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = 16'hC00A;
    do_reset();
    n_checks++;
    if (ir_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b halted=%0b addr=%h required 0 0 0000", ir_valid, halted, imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (ir_valid !== 1'b1 || ir !== 16'hC00A || ir_pc !== 6'd0) begin
      n_fail++;
      $display("FAIL first_fetch: valid=%0b ir=%h pc=%0d required 1 C00A 0", ir_valid, ir, ir_pc);
    end
  endtask

  task automatic test_stall();
    clear_mem();
    mem[0] = 16'hC00A;
    mem[1] = 16'h2000;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ir_valid !== 1'b1 || ir !== 16'hC00A || ir_pc !== 6'd0 || imem_addr !== 16'h0000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%0b ir=%h pc=%0d addr=%h required 1 C00A 0 0000", i, ir_valid, ir, ir_pc, imem_addr);
      end
      @(negedge clk);
    end
    accept_one(1'b0);
    n_checks++;
    if (ir_valid !== 1'b0 || imem_addr !== 16'h0001) begin
      n_fail++;
      $display("FAIL stall_accept: valid=%0b addr=%h required 0 0001", ir_valid, imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (ir_valid !== 1'b1 || ir !== 16'h2000 || ir_pc !== 6'd1) begin
      n_fail++;
      $display("FAIL stall_next: valid=%0b ir=%h pc=%0d required 1 2000 1", ir_valid, ir, ir_pc);
    end
  endtask

  task automatic test_branches();
    clear_mem();
    mem[0] = 16'h800D;
    mem[13] = 16'h8006;
    mem[6] = 16'hA00E;
    mem[14] = 16'h800C;
    mem[12] = 16'hA00E;
    mem[5] = 16'h0000;
    do_reset();
    accept_one(1'b0);
    n_checks++;
    if (imem_addr !== 16'd13) begin n_fail++; $display("FAIL jmp_to_13: addr=%0d required 13", imem_addr); end
    accept_one(1'b0);
    n_checks++;
    if (imem_addr !== 16'd6) begin n_fail++; $display("FAIL jmp_8006: addr=%0d required 6", imem_addr); end
    accept_one(1'b1);
    n_checks++;
    if (imem_addr !== 16'd14) begin n_fail++; $display("FAIL jez_taken: addr=%0d required 14", imem_addr); end
    accept_one(1'b1);
    n_checks++;
    if (imem_addr !== 16'd12) begin n_fail++; $display("FAIL jmp_to_12: addr=%0d required 12", imem_addr); end
    accept_one(1'b0);
    n_checks++;
    if (imem_addr !== 16'd13) begin n_fail++; $display("FAIL jez_not_taken: addr=%0d required 13", imem_addr); end
    mem[13] = 16'hAFC5;
    accept_one(1'b1);
    n_checks++;
    if (imem_addr !== 16'd5) begin n_fail++; $display("FAIL jez_wide_operand: addr=%0d required 5", imem_addr); end
    accept_one(1'b1);
    n_checks++;
    if (imem_addr !== 16'd6) begin n_fail++; $display("FAIL acc_zero_ignored: addr=%0d required 6", imem_addr); end
  endtask

  task automatic test_program();
    int exp_trace[$];
    int dm[16];
    int acc = 0, k = 0, cyc = 0;
    logic done = 1'b0;
    logic [15:0] w;
    for (int i = 0; i <= 13; i++) exp_trace.push_back(i);
    for (int i = 6; i <= 13; i++) exp_trace.push_back(i);
    for (int i = 6; i <= 12; i++) exp_trace.push_back(i);
    exp_trace.push_back(14);
    for (int i = 0; i < 16; i++) dm[i] = 0;
    clear_mem();
    mem[0] = 16'hC00A; mem[1] = 16'h2000; mem[2] = 16'hC003; mem[3] = 16'h2001;
    mem[4] = 16'hC001; mem[5] = 16'h2002; mem[6] = 16'h0001; mem[7] = 16'h6002;
    mem[8] = 16'h2001; mem[9] = 16'h2003; mem[10] = 16'h0000; mem[11] = 16'h0001;
    mem[12] = 16'hA00E; mem[13] = 16'h8006; mem[14] = 16'hE000;
    do_reset();
    ex_ready = 1'b1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      acc_zero = acc == 0;
      if (ir_valid) begin
        n_checks++;
        if (k >= exp_trace.size() || int'(ir_pc) != exp_trace[k]) begin
          n_fail++;
          $display("FAIL prog_trace[%0d]: pc=%0d required %0d", k, ir_pc, k < exp_trace.size() ? exp_trace[k] : -1);
        end
        k++;
        w = ir;
        case (w[15:13])
          3'b000: acc = dm[w[3:0]];
          3'b001: dm[w[3:0]] = acc;
          3'b010: acc = acc + dm[w[3:0]];
          3'b011: acc = acc - dm[w[3:0]];
          3'b110: acc = int'(w[11:0]);
          3'b111: done = 1'b1;
          default: ;
        endcase
        if (done) begin
          n_checks++;
          if (halted !== 1'b0) begin n_fail++; $display("FAIL prog_halt_early: halted=%0b required 0", halted); end
          @(negedge clk);
          n_checks++;
          if (halted !== 1'b1 || ir_valid !== 1'b0 || imem_addr !== 16'd14) begin
            n_fail++;
            $display("FAIL prog_halted: halted=%0b valid=%0b addr=%0d required 1 0 14", halted, ir_valid, imem_addr);
          end
        end
      end
    end
    ex_ready = 1'b0;
    n_checks++;
    if (!done || k != exp_trace.size()) begin
      n_fail++;
      $display("FAIL prog_complete: accepted=%0d required %0d", k, exp_trace.size());
    end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[0] = 16'h803F;
    mem[63] = 16'hC000;
    do_reset();
    accept_one(1'b0);
    @(negedge clk);
    n_checks++;
    if (ir_pc !== 6'd63 || ir !== 16'hC000) begin
      n_fail++;
      $display("FAIL wrap_fetch: pc=%0d ir=%h required 63 C000", ir_pc, ir);
    end
    accept_one(1'b0);
    n_checks++;
    if (imem_addr !== 16'd0) begin n_fail++; $display("FAIL wrap_pc: addr=%0d required 0", imem_addr); end
  endtask

  task automatic test_reset_mid_op();
    clear_mem();
    mem[0] = 16'h8009;
    mem[9] = 16'hE000;
    do_reset();
    @(negedge clk);
    ex_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ex_ready = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_issue: valid=%0b halted=%0b addr=%0d required 0 0 0", ir_valid, halted, imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (ir_valid !== 1'b1 || ir !== 16'h8009 || ir_pc !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_refetch: valid=%0b ir=%h pc=%0d required 1 8009 0", ir_valid, ir, ir_pc);
    end
    accept_one(1'b0);
    accept_one(1'b0);
    ex_ready = 1'b1;
    acc_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (halted !== 1'b1 || ir_valid !== 1'b0 || imem_addr !== 16'd9) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: halted=%0b valid=%0b addr=%0d required 1 0 9", i, halted, ir_valid, imem_addr);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ex_ready = 1'b0;
    acc_zero = 1'b0;
    n_checks++;
    if (ir_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_halt: valid=%0b halted=%0b addr=%0d required 0 0 0", ir_valid, halted, imem_addr);
    end
    @(negedge clk);
    n_checks++;
    if (ir_valid !== 1'b1 || ir !== 16'h8009) begin
      n_fail++;
      $display("FAIL rst_halt_refetch: valid=%0b ir=%h required 1 8009", ir_valid, ir);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branches();
    test_program();
    test_wrap();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
